// File: rtl/i2s_rx_pkg.sv
// Shared types and defaults for the oversampled I2S receiver.
// Channel and state encodings are enums so comparisons stay readable.
package i2s_rx_pkg;

    localparam int unsigned AUDIO_DW_DEF    = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    typedef enum logic {
        WS_LEFT  = 1'b0,
        WS_RIGHT = 1'b1
    } ws_ch_e;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// I2S line inputs plus the deserialised word/strobe outputs of i2s_rx.
// slave = receiver side, master = source/consumer side.
interface i2s_rx_if
    import i2s_rx_pkg::*;
#(
    parameter int unsigned AUDIO_DW = AUDIO_DW_DEF
);
    logic                sck_i;
    logic                ws_i;
    logic                sd_i;
    logic [AUDIO_DW-1:0] l_data_o;
    logic [AUDIO_DW-1:0] r_data_o;
    logic                l_valid_o;
    logic                r_valid_o;
    logic                short_o;
    logic                sync_o;

    modport slave (
        input  sck_i, ws_i, sd_i,
        output l_data_o, r_data_o, l_valid_o, r_valid_o, short_o, sync_o
    );

    modport master (
        output sck_i, ws_i, sd_i,
        input  l_data_o, r_data_o, l_valid_o, r_valid_o, short_o, sync_o
    );
endinterface

// File: rtl/i2s_rx_sync_2ff_edge.sv
// Two-flop synchroniser for an asynchronous input; optionally a third flop
// provides a single-cycle rising-edge indication on the synchronised signal.
module sync_2ff_edge
    import i2s_rx_pkg::*;
#(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);
    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

    generate
        if (EDGE_EN) begin : g_edge
            logic r_s3;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_s3 <= 1'b0;
                end else begin
                    r_s3 <= r_s2;
                end
            end
            assign o_rise = r_s2 & ~r_s3;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/i2s_rx.sv
// Oversampled Philips-I2S slave receiver: deserialises MSB-first slots and
// publishes left/right words with one-cycle strobes once frame sync is found.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int unsigned AUDIO_DW    = AUDIO_DW_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic    clk_i,
    input  logic    rst_i,
    i2s_rx_if.slave bus
);
    localparam int unsigned CW = $clog2(AUDIO_DW + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]       CNT_FULL = CW'(AUDIO_DW);
    localparam logic [TW-1:0]       TO_TERM  = TW'(TIMEOUT_CYC);
    localparam logic [AUDIO_DW-1:0] MSB_ONE  = {1'b1, {(AUDIO_DW-1){1'b0}}};

    logic w_sck_rise;
    logic w_ws_s;
    logic w_sd_s;
    logic w_unused_sck_q;
    logic w_unused_ws_rise;
    logic w_unused_sd_rise;

    sync_2ff_edge #(.EDGE_EN(1'b1)) u_sync_sck (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_d    (bus.sck_i),
        .o_q    (w_unused_sck_q),
        .o_rise (w_sck_rise)
    );

    sync_2ff_edge #(.EDGE_EN(1'b0)) u_sync_ws (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_d    (bus.ws_i),
        .o_q    (w_ws_s),
        .o_rise (w_unused_ws_rise)
    );

    sync_2ff_edge #(.EDGE_EN(1'b0)) u_sync_sd (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_d    (bus.sd_i),
        .o_q    (w_sd_s),
        .o_rise (w_unused_sd_rise)
    );

    rx_state_e           r_state;
    rx_state_e           w_state_nxt;
    logic [AUDIO_DW-1:0] r_shreg;
    logic [AUDIO_DW-1:0] w_shreg_nxt;
    logic [AUDIO_DW-1:0] w_shreg_cap;
    logic [AUDIO_DW-1:0] w_bit_mask;
    logic [CW-1:0]       r_bit_cnt;
    logic [CW-1:0]       w_bit_cnt_nxt;
    logic [CW-1:0]       w_bit_cnt_cap;
    ws_ch_e              r_ws_prev;
    ws_ch_e              w_ws_prev_nxt;
    logic [TW-1:0]       r_to_cnt;
    logic [TW-1:0]       w_to_cnt_nxt;
    logic                w_slot_edge;
    logic [AUDIO_DW-1:0] r_l_data;
    logic [AUDIO_DW-1:0] w_l_data_nxt;
    logic [AUDIO_DW-1:0] r_r_data;
    logic [AUDIO_DW-1:0] w_r_data_nxt;
    logic                r_l_valid;
    logic                w_l_valid_nxt;
    logic                r_r_valid;
    logic                w_r_valid_nxt;
    logic                r_short;
    logic                w_short_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mask selects the bit slot for the current count; it is zero once the
    // count saturates, so surplus bits leave the word untouched.
    assign w_bit_mask    = MSB_ONE >> r_bit_cnt;
    assign w_shreg_cap   = (r_shreg & ~w_bit_mask) | ({AUDIO_DW{w_sd_s}} & w_bit_mask);
    assign w_bit_cnt_cap = (r_bit_cnt < CNT_FULL) ? r_bit_cnt + 1'b1 : r_bit_cnt;
    assign w_slot_edge   = w_sck_rise && (ws_ch_e'(w_ws_s) != r_ws_prev);

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_ws_prev_nxt = r_ws_prev;
        w_to_cnt_nxt  = (r_to_cnt == TO_TERM) ? r_to_cnt : r_to_cnt + 1'b1;
        w_l_data_nxt  = r_l_data;
        w_r_data_nxt  = r_r_data;
        w_l_valid_nxt = 1'b0;
        w_r_valid_nxt = 1'b0;
        w_short_nxt   = 1'b0;

        if (w_sck_rise) begin
            w_to_cnt_nxt  = '0;
            w_ws_prev_nxt = ws_ch_e'(w_ws_s);
            if (w_slot_edge) begin
                // The edge bit closes the previous slot; in SYNC that slot is partial.
                if (r_state == ST_RUN) begin
                    w_short_nxt = (w_bit_cnt_cap < CNT_FULL);
                    if (r_ws_prev == WS_LEFT) begin
                        w_l_valid_nxt = 1'b1;
                        w_l_data_nxt  = w_shreg_cap;
                    end else begin
                        w_r_valid_nxt = 1'b1;
                        w_r_data_nxt  = w_shreg_cap;
                    end
                end
                w_state_nxt   = ST_RUN;
                w_shreg_nxt   = '0;
                w_bit_cnt_nxt = '0;
            end else begin
                w_shreg_nxt   = w_shreg_cap;
                w_bit_cnt_nxt = w_bit_cnt_cap;
            end
        end else if (r_to_cnt == TO_TERM) begin
            w_state_nxt   = ST_SYNC;
            w_shreg_nxt   = '0;
            w_bit_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_ws_prev <= WS_LEFT;
            r_to_cnt  <= '0;
            r_l_data  <= '0;
            r_r_data  <= '0;
            r_l_valid <= 1'b0;
            r_r_valid <= 1'b0;
            r_short   <= 1'b0;
        end else begin
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_ws_prev <= w_ws_prev_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_l_data  <= w_l_data_nxt;
            r_r_data  <= w_r_data_nxt;
            r_l_valid <= w_l_valid_nxt;
            r_r_valid <= w_r_valid_nxt;
            r_short   <= w_short_nxt;
        end
    end

    assign bus.l_data_o  = r_l_data;
    assign bus.r_data_o  = r_r_data;
    assign bus.l_valid_o = r_l_valid;
    assign bus.r_valid_o = r_r_valid;
    assign bus.short_o   = r_short;
    assign bus.sync_o    = (r_state == ST_RUN);
endmodule

// File: tb/tb_i2s_rx.sv
// Randomised bench for i2s_rx: builds I2S bit streams, predicts the published
// words from the WS transitions alone, and compares against captured strobes.
module tb_i2s_rx;
    import i2s_rx_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    i2s_rx_if #(.AUDIO_DW(DW)) bus ();

    i2s_rx #(.AUDIO_DW(DW), .TIMEOUT_CYC(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          cyc = 0;
    int          last_rise_cyc = 0;
    logic        prev_l = 1'b0;
    logic        prev_r = 1'b0;

    bit         ws_q[$];
    bit         sd_q[$];
    logic [9:0] exp_q[$];   // {channel, short, data}
    logic [9:0] act_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.l_valid_o || bus.r_valid_o)
            check_eq("excl_valid", {31'd0, bus.l_valid_o & bus.r_valid_o}, 32'd0);
        if (bus.l_valid_o) begin
            check_eq("l_pulse_width", {31'd0, prev_l}, 32'd0);
            act_q.push_back({1'b0, bus.short_o, bus.l_data_o});
        end
        if (bus.r_valid_o) begin
            check_eq("r_pulse_width", {31'd0, prev_r}, 32'd0);
            act_q.push_back({1'b1, bus.short_o, bus.r_data_o});
        end
        if (bus.short_o)
            check_eq("short_with_valid", {31'd0, bus.l_valid_o | bus.r_valid_o}, 32'd1);
        prev_l <= bus.l_valid_o;
        prev_r <= bus.r_valid_o;
    end

    task automatic new_stream();
        ws_q.delete();
        sd_q.delete();
    endtask

    // MSB first; the LSB already carries the next slot's WS (one-bit WS lead).
    task automatic add_slot(input bit ch, input logic [31:0] word, input int unsigned n,
                            input bit next_ch);
        for (int unsigned k = 0; k < n; k++) begin
            sd_q.push_back(word[n-1-k]);
            ws_q.push_back((k == n - 1) ? next_ch : ch);
        end
    endtask

    // A word spans the rises after one WS change up to and including the next;
    // it is published only if the opening change followed an earlier one.
    function automatic void build_expected(input bit prev);
        bit cur = prev;
        int start = -1;
        exp_q.delete();
        for (int unsigned j = 0; j < ws_q.size(); j++) begin
            if (ws_q[j] != cur) begin
                if (start >= 0) begin
                    int         len = int'(j) - start;
                    logic [7:0] d   = 8'h00;
                    logic [7:0] msb = 8'h80;
                    for (int k = 0; k < len && k < int'(DW); k++)
                        if (sd_q[start + 1 + k]) d = d | (msb >> k);
                    exp_q.push_back({cur, (len < int'(DW)), d});
                end
                start = int'(j);
                cur   = ws_q[j];
            end
        end
    endfunction

    task automatic drive_stream(input int unsigned lo_min, input int unsigned lo_max,
                                input int unsigned hi_min, input int unsigned hi_max);
        for (int unsigned j = 0; j < ws_q.size(); j++) begin
            bus.sck_i = 1'b0;
            bus.ws_i  = ws_q[j];
            bus.sd_i  = sd_q[j];
            repeat ($urandom_range(lo_max, lo_min)) @(negedge clk);
            bus.sck_i     = 1'b1;
            last_rise_cyc = cyc;
            repeat ($urandom_range(hi_max, hi_min)) @(negedge clk);
        end
        bus.sck_i = 1'b0;
    endtask

    task automatic run_burst(input bit prev, input string tag,
                             input int unsigned lo_min, input int unsigned lo_max,
                             input int unsigned hi_min, input int unsigned hi_max);
        build_expected(prev);
        act_q.delete();
        drive_stream(lo_min, lo_max, hi_min, hi_max);
        repeat (10) @(negedge clk);
        check_eq({tag, "_count"}, act_q.size(), exp_q.size());
        for (int unsigned i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check_eq({tag, "_word"}, {22'd0, act_q[i]}, {22'd0, exp_q[i]});
    endtask

    task automatic do_reset(input int unsigned n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_l_data"}, {24'd0, bus.l_data_o}, 32'd0);
        check_eq({tag, "_r_data"}, {24'd0, bus.r_data_o}, 32'd0);
        check_eq({tag, "_strobes"},
                 {29'd0, bus.l_valid_o, bus.r_valid_o, bus.short_o}, 32'd0);
        check_eq({tag, "_sync"}, {31'd0, bus.sync_o}, 32'd0);
    endtask

    initial begin
        bit         last_ws;
        logic [7:0] held_l;

        bus.sck_i = 1'b0;
        bus.ws_i  = 1'b0;
        bus.sd_i  = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Test 1: 8-bit slots, fixed words, SCK = clk/8
        new_stream();
        for (int unsigned f = 0; f < 3; f++) begin
            add_slot(1'b0, 32'hA5, 8, 1'b1);
            add_slot(1'b1, 32'h3C, 8, 1'b0);
        end
        run_burst(1'b0, "t1", 4, 4, 4, 4);
        check_eq("t1_l_data", {24'd0, bus.l_data_o}, 32'hA5);
        check_eq("t1_r_data", {24'd0, bus.r_data_o}, 32'h3C);
        check_eq("t1_sync", {31'd0, bus.sync_o}, 32'd1);

        // Test 2: 16-bit slots truncate to the top byte
        do_reset(1);
        new_stream();
        for (int unsigned f = 0; f < 3; f++) begin
            add_slot(1'b0, 32'hC3F0, 16, 1'b1);
            add_slot(1'b1, 32'h0F81, 16, 1'b0);
        end
        run_burst(1'b0, "t2", 4, 4, 4, 4);
        check_eq("t2_l_data", {24'd0, bus.l_data_o}, 32'hC3);
        check_eq("t2_r_data", {24'd0, bus.r_data_o}, 32'h0F);

        // Test 3: 5-bit slots zero-pad and flag short
        do_reset(1);
        new_stream();
        for (int unsigned f = 0; f < 3; f++) begin
            add_slot(1'b0, 32'h16, 5, 1'b1);
            add_slot(1'b1, 32'h0D, 5, 1'b0);
        end
        run_burst(1'b0, "t3", 4, 4, 4, 4);
        check_eq("t3_l_data", {24'd0, bus.l_data_o}, 32'hB0);
        check_eq("t3_r_data", {24'd0, bus.r_data_o}, 32'h68);
        if (act_q.size() > 0)
            check_eq("t3_short", {31'd0, act_q[act_q.size()-1][8]}, 32'd1);

        // Test 4: SCK stalls mid-slot, timeout, then resync
        do_reset(1);
        new_stream();
        for (int unsigned f = 0; f < 2; f++) begin
            add_slot(1'b0, $urandom_range(255, 0), 8, 1'b1);
            add_slot(1'b1, $urandom_range(255, 0), 8, 1'b0);
        end
        add_slot(1'b0, 32'hF, 4, 1'b0);
        run_burst(1'b0, "t4a", 4, 4, 4, 4);
        last_ws = ws_q[ws_q.size()-1];
        held_l  = 8'h00;
        for (int unsigned i = 0; i < exp_q.size(); i++)
            if (exp_q[i][9] == 1'b0) held_l = exp_q[i][7:0];
        while (cyc < last_rise_cyc + 240) @(negedge clk);
        check_eq("t4_sync_before_timeout", {31'd0, bus.sync_o}, 32'd1);
        while (cyc < last_rise_cyc + 275) @(negedge clk);
        check_eq("t4_sync_after_timeout", {31'd0, bus.sync_o}, 32'd0);
        check_eq("t4_l_held", {24'd0, bus.l_data_o}, {24'd0, held_l});
        new_stream();
        for (int unsigned f = 0; f < 2; f++) begin
            add_slot(1'b0, $urandom_range(255, 0), 8, 1'b1);
            add_slot(1'b1, $urandom_range(255, 0), 8, 1'b0);
        end
        run_burst(last_ws, "t4b", 4, 4, 4, 4);

        // Test 5: single-cycle reset in the middle of a right slot
        do_reset(1);
        new_stream();
        add_slot(1'b0, 32'h5A, 8, 1'b1);
        add_slot(1'b1, 32'h96, 8, 1'b0);
        add_slot(1'b0, 32'hE7, 8, 1'b1);
        add_slot(1'b1, 32'h0B, 4, 1'b1);
        run_burst(1'b0, "t5a", 4, 4, 4, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outputs_zero("t5_after_reset");
        new_stream();
        for (int unsigned f = 0; f < 2; f++) begin
            add_slot(1'b0, $urandom_range(255, 0), 8, 1'b1);
            add_slot(1'b1, $urandom_range(255, 0), 8, 1'b0);
        end
        run_burst(1'b0, "t5b", 4, 4, 4, 4);

        // Test 6: jittered SCK, random words and slot lengths
        do_reset(1);
        new_stream();
        for (int unsigned f = 0; f < 200; f++) begin
            add_slot(1'b0, $urandom, $urandom_range(10, 6), 1'b1);
            add_slot(1'b1, $urandom, $urandom_range(10, 6), 1'b0);
        end
        run_burst(1'b0, "t6", 2, 5, 2, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
